// File: rtl/rand_req_arbiter_pkg.sv
// rtl/rand_req_arbiter_pkg.sv - shared constants and state encoding for the random-value arbiter
package rand_req_arbiter_pkg;

  localparam int STIR_CYCLES_DEF = 5;
  localparam int LFSR_WIDTH      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STIR    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/rand_req_arbiter_rr.sv
// rtl/rand_req_arbiter_rr.sv - two-input round-robin picker, purely combinational
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_win
);

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    o_win = 2'b00;
    case (i_req)
      2'b01:   o_win = 2'b01;
      2'b10:   o_win = 2'b10;
      2'b11:   o_win = i_last ? 2'b01 : 2'b10;
      default: o_win = 2'b00;
    endcase
  end

endmodule

// File: rtl/rand_req_arbiter.sv
// rtl/rand_req_arbiter.sv - shares one LFSR between two requesters, stirring it per grant
module rand_req_arbiter
  import rand_req_arbiter_pkg::*;
#(
  parameter int STIR_CYCLES = STIR_CYCLES_DEF,
  parameter int WIDTH       = LFSR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] lfsr_q,
  output logic             lfsr_count,
  output logic [1:0]       grant,
  output logic [WIDTH-1:0] rand_out,
  output logic [1:0]       rand_valid,
  output logic             busy
);

  localparam int CW = $clog2(STIR_CYCLES + 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_ptr;
  logic [1:0]       r_grant;
  logic             r_count;
  logic [WIDTH-1:0] r_rand;
  logic [1:0]       r_valid;

  logic [1:0]       w_win;
  logic             w_owner_req;

  rr_arbiter2 u_rr (
    .i_req  (req),
    .i_last (r_ptr),
    .o_win  (w_win)
  );

  // The owner still wants the value while its own req bit stays high.
  assign w_owner_req = |(req & r_grant);

  assign lfsr_count = r_count;
  assign grant      = r_grant;
  assign rand_out   = r_rand;
  assign rand_valid = r_valid;
  assign busy       = (r_state != IDLE);

  // Grant, stir the LFSR for a fixed step count, capture, then hold until the owner lets go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= 1'b1;
      r_grant <= 2'b00;
      r_count <= 1'b0;
      r_rand  <= '0;
      r_valid <= 2'b00;
    end else begin
      r_valid <= 2'b00;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_grant <= w_win;
            r_count <= 1'b1;
            r_cnt   <= CW'(STIR_CYCLES - 1);
            r_state <= STIR;
          end
        end
        STIR: begin
          if (!w_owner_req) begin
            r_count <= 1'b0;
            r_grant <= 2'b00;
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            r_count <= 1'b0;
            r_state <= CAPTURE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        CAPTURE: begin
          if (!w_owner_req) begin
            r_grant <= 2'b00;
            r_state <= IDLE;
          end else begin
            r_rand  <= lfsr_q;
            r_valid <= r_grant;
            r_ptr   <= r_grant[1];
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (!w_owner_req) begin
            r_grant <= 2'b00;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_req_arbiter.sv
// tb/tb_rand_req_arbiter.sv - scoreboard bench for rand_req_arbiter with an external LFSR model
module tb_rand_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] lfsr_q = 4'h0;
  logic       lfsr_count;
  logic [1:0] grant;
  logic [3:0] rand_out;
  logic [1:0] rand_valid;
  logic       busy;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] who;
    logic [3:0] val;
    int         cyc;
  } exp_t;
  exp_t sbq[$];

  int         m_ptr;
  logic [3:0] m_lfsr;
  logic [3:0] m_rand;

  rand_req_arbiter #(.STIR_CYCLES(5), .WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .lfsr_q     (lfsr_q),
    .lfsr_count (lfsr_count),
    .grant      (grant),
    .rand_out   (rand_out),
    .rand_valid (rand_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] lfsr_step(logic [3:0] v);
    return {~(v[0] ^ v[1]), v[3:1]};
  endfunction

  function automatic logic [3:0] lfsr_adv(logic [3:0] v, int n);
    logic [3:0] t = v;
    for (int i = 0; i < n; i++) t = lfsr_step(t);
    return t;
  endfunction

  function automatic logic [1:0] oh(int w);
    return (w != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic int pick(logic [1:0] m);
    if (m == 2'b01) return 0;
    if (m == 2'b10) return 1;
    return (m_ptr == 0) ? 1 : 0;
  endfunction

  // External LFSR: shifts whenever the arbiter enables it, never reset.
  always @(posedge clk) if (lfsr_count) lfsr_q <= lfsr_step(lfsr_q);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every valid strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst) begin
      chk("grant_not_both", {31'd0, grant == 2'b11}, 32'd0);
      if (rand_valid !== 2'b00) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got %0h expected none (cycle %0d)", rand_valid, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("valid_who", {30'd0, rand_valid}, {30'd0, e.who});
          chk("rand_out", {28'd0, rand_out}, {28'd0, e.val});
          chk("valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // One grant cycle; DUT idle and called just after a negedge. abort_k>0 drops req in that grant cycle.
  task automatic serve(logic [1:0] mask, int hold, int abort_k);
    int   w;
    int   c0;
    exp_t e;
    w = pick(mask);
    req = mask;
    @(negedge clk);
    c0 = cyc;
    chk("grant_rise", {30'd0, grant}, {30'd0, oh(w)});
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("count_c1", {31'd0, lfsr_count}, 32'd1);
    if (abort_k > 0) begin
      for (int i = 2; i <= abort_k; i++) begin
        @(negedge clk);
        chk("count_pre_abort", {31'd0, lfsr_count}, (i <= 5) ? 32'd1 : 32'd0);
      end
      req = 2'b00;
      @(negedge clk);
      chk("abort_grant", {30'd0, grant}, 32'd0);
      chk("abort_count", {31'd0, lfsr_count}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_rand_out", {28'd0, rand_out}, {28'd0, m_rand});
      m_lfsr = lfsr_adv(m_lfsr, (abort_k < 5) ? abort_k : 5);
      return;
    end
    m_lfsr = lfsr_adv(m_lfsr, 5);
    m_rand = m_lfsr;
    m_ptr  = w;
    e.who = oh(w);
    e.val = m_lfsr;
    e.cyc = c0 + 6;
    sbq.push_back(e);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      chk("count_run", {31'd0, lfsr_count}, (i <= 5) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_grant", {30'd0, grant}, {30'd0, oh(w)});
      chk("hold_busy", {31'd0, busy}, 32'd1);
    end
    req = mask & ~oh(w);
    @(negedge clk);
    chk("release_grant", {30'd0, grant}, 32'd0);
    chk("release_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] m;
    int         ab;
    int         w;
    rst = 1'b1;
    req = 2'b00;
    m_ptr = 1;
    m_lfsr = 4'h0;
    m_rand = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_count", {31'd0, lfsr_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rand_out", {28'd0, rand_out}, 32'd0);
    chk("rst_valid", {30'd0, rand_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    serve(2'b01, 2, 0);
    chk("directed_first_value", {28'd0, rand_out}, 32'hB);
    serve(2'b10, 1, 0);
    chk("directed_second_value", {28'd0, rand_out}, 32'h4);

    // Tie with a long hold: requester 0 first, requester 1 waits then follows.
    serve(2'b11, 10, 0);
    serve(2'b10, 0, 0);

    // Abort in the third stir cycle, then a tie goes to the same requester.
    w = pick(2'b11);
    serve(2'b11, 0, 3);
    chk("abort_tie_winner", pick(2'b11), w);
    serve(2'b11, 0, 0);
    req = 2'b00;
    @(negedge clk);

    // Asynchronous reset mid-stir.
    req = 2'b01;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_count", {31'd0, lfsr_count}, 32'd0);
    chk("async_grant", {30'd0, grant}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    req = 2'b00;
    @(negedge clk);
    chk("async_rand_out", {28'd0, rand_out}, 32'd0);
    chk("async_valid", {30'd0, rand_valid}, 32'd0);
    rst = 1'b0;
    m_ptr = 1;
    m_rand = 4'h0;
    m_lfsr = lfsr_adv(m_lfsr, 2);
    @(negedge clk);

    for (int k = 0; k < 24; k++) begin
      m  = 2'($urandom_range(1, 3));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      w  = pick(m);
      serve(m, int'($urandom_range(0, 4)), ab);
      if (m == 2'b11 && ab == 0) serve(oh(1 - w), int'($urandom_range(0, 3)), 0);
      req = 2'b00;
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
